switch_allocator: RTL and testbench
===================================

# switch_allocator

Switch allocator for the quadtree router. It accepts the per-input `route_port` masks from the five routing computers and grants the crossbar each cycle with round-robin fairness. Unicast and multicast (`01111` broadcast) requests are granted all-or-nothing. A grant also requires downstream buffer space, which the block tracks with per-output credit counters. It sits between the routing-computer stage and the crossbar/output registers of every router level (root, internal, leaf).

## Interface
- `CREDIT`, default 4: downstream buffer depth per output port, which is also the reset credit count.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `DIRECTION` (5): bit i set means input port i holds a routed flit.
- `req_port` in 5×`DIRECTION` (25): bits [5i+4:5i] carry the route mask of input i. Bits 0–3 are the children; bit 4 is the parent/local port.
- `credit_in` in 5: one-cycle pulse per output. Output o's downstream freed one slot.
- `grant` out 5: registered. Bit i means input i's flit is taken this cycle, and the upstream buffer pops.
- `xbar_sel` out 25: registered. Bits [5o+4:5o] are a one-hot input select for output o, all zero when idle.
- `out_valid` out 5: registered. Output o carries a flit this cycle.

## Operation
- **Eligibility.** Input i is eligible when `req_valid[i]=1` and `grant[i]=0`. The currently registered grant masks the input, which prevents a double grant before the pop takes effect.
- **Zero mask.** An eligible input with mask 0 is an unroutable/default flit. It is granted unconditionally (dropped), drives no output, and does not affect the pointer.
- **Round-robin pointer.** `rr_ptr` is a value 0–4 and resets to 0. Inputs are visited in order `rr_ptr`, `rr_ptr+1`, … mod 5.
- **Greedy allocation.** A visited input with nonzero mask M is granted if three conditions all hold:
  - M is disjoint from the outputs already claimed this cycle.
  - Every output in M has `credit_cnt > 0`, using the registered count; a same-cycle `credit_in` does not count.
  - M is disjoint from the reserved set.
- **Granted input.** All of its outputs are claimed.
- **Reservation.** If the first visited eligible nonzero input fails only because of credits, its entire mask becomes reserved for this cycle. Lower-priority inputs cannot use those outputs, which guarantees forward progress for broadcasts.
- **Pointer update.** `rr_ptr` becomes the first granted nonzero input + 1 (mod 5). If no nonzero grant occurs, it is unchanged.
- **Credit counter per output.** Width is $clog2(CREDIT+1) and reset value is `CREDIT`.
  - Allocation claims output o and no `credit_in[o]`: decrement.
  - `credit_in[o]` and no claim: increment.
  - Both in the same cycle: unchanged.
  - `credit_in` while at `CREDIT`: ignored, and a simulation assertion fires.
- **Registered outputs.** `grant`, `xbar_sel` and `out_valid` are registered from the allocation result. `out_valid[o]` equals the OR of `xbar_sel[5o+4:5o]`.

## Timing
- **Reset.** While `rst=1`, asynchronously: `grant=0`, `xbar_sel=0`, `out_valid=0`, `rr_ptr=0`, all credit counters at `CREDIT`. A request pending at reset is forgotten; upstream re-presents it after reset.
- **Latency.** A request sampled at edge t produces `grant`/`xbar_sel` valid during cycle t+1.
  - Upstream keeps `req_valid`/`req_port` stable until it sees `grant`.
  - Upstream pops on the edge ending cycle t+1.
- **Throughput.** Each input receives a grant at most every other cycle; see the grant masking above.
- **Credit return.** A `credit_in` at edge t makes the output eligible for allocation at edge t+1.
- **Stable inputs.** The block has no internal request storage. A request withdrawn before grant is simply not granted.

## Structure
- Defined in `router.vh`:
  - Reused: `DIRECTION` (5) and the `DIR_LOCAL`/port bit positions.
  - Added: `CREDIT_WIDTH` and an `ARB_PORT_PARENT` (bit 4) define.
- Sub-module `credit_counter`: one instance per output. Its ports are `clk`, `rst`, `dec`, `inc`, and the `avail` output (count > 0).
- The allocation loop is combinational inside `switch_allocator`. It unrolls over 5 inputs from `rr_ptr`.

## Test plan
- **Single unicast.** Input 0 with `req_port` `00100` → next cycle `grant=00001`, `xbar_sel[14:10]=00001`, `out_valid=00100`, `credit_cnt[2]` 4→3, `rr_ptr`=1.
- **Broadcast vs unicast conflict.** Inputs 4 (`01111`) and 1 (`00010`) with `rr_ptr`=0 → input 1 granted. The following cycle input 4 is granted all four children, `out_valid=01111`.
- **Zero mask.** Input 3 with mask `00000` while input 0 requests `10000` → both granted in the same cycle, `out_valid=10000`, `rr_ptr`=1.
- **Credit exhaustion and reservation.** Drain `credit_cnt[0]` to 0. Input 2 (highest priority) requests `00011` while input 3 requests `00010` → no grant, and output 1 stays idle. Pulse `credit_in[0]` → input 2 is granted one cycle later.
- **Simultaneous claim and credit return.** Output 1 is claimed and `credit_in[1]` arrives in the same cycle → count unchanged. Pulsing `credit_in` while the count is at 4 → the count stays at 4 and the assertion fires.
- **Reset mid-operation.** Assert `rst` asynchronously while `grant≠0` → all outputs are 0 immediately, counters return to 4, and `rr_ptr`=0.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Shared constants and helpers for the quadtree router switch allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Port numbering: bits 0-3 are the four children, bit 4 is the parent/local port.
package switch_allocator_pkg;

   localparam int DIRECTION       = 5;
   localparam int DIR_CHILD0      = 0;
   localparam int DIR_CHILD1      = 1;
   localparam int DIR_CHILD2      = 2;
   localparam int DIR_CHILD3      = 3;
   localparam int DIR_LOCAL       = 4;
   localparam int ARB_PORT_PARENT = 4;

   localparam int CREDIT_DEFAULT  = 4;
   localparam int CREDIT_WIDTH    = $clog2(CREDIT_DEFAULT + 1);

   typedef logic [DIRECTION-1:0] port_mask_t;

   // Maps 0..2*DIRECTION-1 back onto a port index 0..DIRECTION-1.
   function automatic logic [2:0] port_wrap(input int v);
      if (v >= DIRECTION) begin
         return 3'(v - DIRECTION);
      end
      return 3'(v);
   endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between routing computers, allocator and crossbar.
// Latency: n/a (wires only).
// Backpressure: grant acts as the pop/ready for each input; credit_in returns downstream space.
//
// Ports:
//   req_valid  per-input flit present
//   req_port   per-input route mask, input i at [5i+4:5i]
//   credit_in  per-output one-cycle credit return pulse
//   grant      per-input pop (registered)
//   xbar_sel   per-output one-hot input select, output o at [5o+4:5o]
//   out_valid  per-output flit present on crossbar
interface switch_allocator_if;
   import switch_allocator_pkg::*;

   logic [DIRECTION-1:0]           req_valid;
   logic [DIRECTION*DIRECTION-1:0] req_port;
   logic [DIRECTION-1:0]           credit_in;
   logic [DIRECTION-1:0]           grant;
   logic [DIRECTION*DIRECTION-1:0] xbar_sel;
   logic [DIRECTION-1:0]           out_valid;

   // Upstream/environment side.
   modport master (
      output req_valid,
      output req_port,
      output credit_in,
      input  grant,
      input  xbar_sel,
      input  out_valid
   );

   // Allocator side.
   modport slave (
      input  req_valid,
      input  req_port,
      input  credit_in,
      output grant,
      output xbar_sel,
      output out_valid
   );
endinterface

// File: rtl/switch_allocator_credit_counter.sv
// Per-output downstream credit counter, reset full at CREDIT.
// Latency: inc/dec take effect on the next edge; avail reflects the registered count.
// Backpressure: avail=0 blocks allocation to this output until a credit returns.
//
// Ports: clk, rst (async active-high), dec (output claimed), inc (credit returned),
//        avail (count > 0).
module credit_counter #(
   parameter int CREDIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic dec,
   input  logic inc,
   output logic avail
);
   localparam int          W    = $clog2(CREDIT + 1);
   localparam logic [W-1:0] FULL = W'(CREDIT);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= FULL;
      end else if (dec && !inc) begin
         // dec is only raised when avail=1, so no underflow.
         count <= count - 1'b1;
      end else if (inc && !dec && count != FULL) begin
         count <= count + 1'b1;
      end
   end

   assign avail = (count != '0);

   // A credit returned to a full counter means upstream/downstream disagree on depth.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(inc && !dec && count == FULL))
            else $warning("credit_counter: credit_in on full counter ignored");
      end
   end

endmodule

// File: rtl/switch_allocator.sv
// Round-robin all-or-nothing switch allocator with per-output credit tracking.
// Latency: request sampled at edge t -> grant/xbar_sel/out_valid registered, valid in cycle t+1.
// Backpressure: grant pops the input; outputs without credit (or reserved) are not allocated.
//
// Ports: clk, rst (async active-high), bus (switch_allocator_if.slave:
//        req_valid/req_port/credit_in in, grant/xbar_sel/out_valid out).
module switch_allocator
   import switch_allocator_pkg::*;
#(
   parameter int CREDIT = CREDIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   switch_allocator_if.slave     bus
);

   logic [2:0]                     rr_ptr;
   logic [2:0]                     ptr_n;
   port_mask_t                     avail;
   port_mask_t                     claimed;
   port_mask_t                     reserved;
   port_mask_t                     grant_n;
   logic [DIRECTION*DIRECTION-1:0] sel_n;

   // Greedy allocation, unrolled over the five inputs starting at rr_ptr.
   always_comb begin
      int         idx;
      port_mask_t mask;
      logic       first_seen;
      logic       first_grant;
      logic       no_conflict;
      logic       creds_ok;
      logic       no_resv;

      claimed     = '0;
      reserved    = '0;
      grant_n     = '0;
      sel_n       = '0;
      ptr_n       = rr_ptr;
      first_seen  = 1'b0;
      first_grant = 1'b0;
      idx         = 0;
      mask        = '0;
      no_conflict = 1'b0;
      creds_ok    = 1'b0;
      no_resv     = 1'b0;

      for (int k = 0; k < DIRECTION; k++) begin
         idx  = int'(port_wrap(int'(rr_ptr) + k));
         mask = bus.req_port[idx*DIRECTION +: DIRECTION];
         // The registered grant masks the input until its pop lands.
         if (bus.req_valid[idx] && !bus.grant[idx]) begin
            if (mask == '0) begin
               // Unroutable flit: drop it, no output, no pointer effect.
               grant_n[idx] = 1'b1;
            end else begin
               no_conflict = ((mask & claimed) == '0);
               creds_ok    = ((mask & ~avail) == '0);
               no_resv     = ((mask & reserved) == '0);
               if (no_conflict && creds_ok && no_resv) begin
                  grant_n[idx] = 1'b1;
                  claimed      = claimed | mask;
                  for (int o = 0; o < DIRECTION; o++) begin
                     if (mask[o]) begin
                        sel_n[o*DIRECTION + idx] = 1'b1;
                     end
                  end
                  if (!first_grant) begin
                     first_grant = 1'b1;
                     ptr_n       = port_wrap(idx + 1);
                  end
               end else if (!first_seen && !creds_ok) begin
                  // Highest-priority nonzero request starved only by credits:
                  // hold its outputs so a wide (broadcast) mask can't be starved.
                  reserved = mask;
               end
               first_seen = 1'b1;
            end
         end
      end
   end

   genvar o;
   generate
      for (o = 0; o < DIRECTION; o++) begin : g_out
         credit_counter #(
            .CREDIT (CREDIT)
         ) u_cc (
            .clk   (clk),
            .rst   (rst),
            .dec   (claimed[o]),
            .inc   (bus.credit_in[o]),
            .avail (avail[o])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.grant     <= '0;
         bus.xbar_sel  <= '0;
         bus.out_valid <= '0;
         rr_ptr        <= '0;
      end else begin
         bus.grant     <= grant_n;
         bus.xbar_sel  <= sel_n;
         // claimed is exactly the OR of each output's select slice.
         bus.out_valid <= claimed;
         rr_ptr        <= ptr_n;
      end
   end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator.
module tb_switch_allocator;
   import switch_allocator_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   switch_allocator_if bus();

   switch_allocator #(
      .CREDIT (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid = '0;
      bus.req_port  = '0;
      bus.credit_in = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      checks++;
      if (bus.grant !== 5'b0) begin
         errors++; $display("FAIL reset_grant: got %b want 00000", bus.grant);
      end
      checks++;
      if (bus.xbar_sel !== 25'b0) begin
         errors++; $display("FAIL reset_xbar_sel: got %h want 0", bus.xbar_sel);
      end
      checks++;
      if (bus.out_valid !== 5'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 00000", bus.out_valid);
      end
      checks++;
      if (dut.rr_ptr !== 3'd0) begin
         errors++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr);
      end
      checks++;
      if (dut.g_out[0].u_cc.count !== 3'd4 || dut.g_out[4].u_cc.count !== 3'd4) begin
         errors++; $display("FAIL reset_credit: got %0d/%0d want 4/4",
                            dut.g_out[0].u_cc.count, dut.g_out[4].u_cc.count);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_unicast();
      apply_reset();
      bus.req_valid    = 5'b00001;
      bus.req_port[4:0] = 5'b00100;
      step();
      checks++;
      if (bus.grant !== 5'b00001) begin
         errors++; $display("FAIL uni_grant: got %b want 00001", bus.grant);
      end
      checks++;
      if (bus.xbar_sel[14:10] !== 5'b00001 || bus.xbar_sel !== 25'h0000400) begin
         errors++; $display("FAIL uni_xbar_sel: got %h want 0000400", bus.xbar_sel);
      end
      checks++;
      if (bus.out_valid !== 5'b00100) begin
         errors++; $display("FAIL uni_out_valid: got %b want 00100", bus.out_valid);
      end
      checks++;
      if (dut.g_out[2].u_cc.count !== 3'd3) begin
         errors++; $display("FAIL uni_credit: got %0d want 3", dut.g_out[2].u_cc.count);
      end
      checks++;
      if (dut.rr_ptr !== 3'd1) begin
         errors++; $display("FAIL uni_rr_ptr: got %0d want 1", dut.rr_ptr);
      end
      // Request still held this cycle: the registered grant must mask it.
      step();
      checks++;
      if (bus.grant !== 5'b0 || bus.out_valid !== 5'b0) begin
         errors++; $display("FAIL uni_mask: got grant %b out_valid %b want 00000/00000",
                            bus.grant, bus.out_valid);
      end
      clear_inputs();
   endtask

   task automatic test_broadcast();
      apply_reset();
      bus.req_valid      = 5'b10010;
      bus.req_port[9:5]   = 5'b00010;
      bus.req_port[24:20] = 5'b01111;
      step();
      checks++;
      if (bus.grant !== 5'b00010 || bus.out_valid !== 5'b00010) begin
         errors++; $display("FAIL bc_first: got grant %b out_valid %b want 00010/00010",
                            bus.grant, bus.out_valid);
      end
      checks++;
      if (dut.rr_ptr !== 3'd2) begin
         errors++; $display("FAIL bc_rr_ptr1: got %0d want 2", dut.rr_ptr);
      end
      step();
      checks++;
      if (bus.grant !== 5'b10000 || bus.out_valid !== 5'b01111) begin
         errors++; $display("FAIL bc_second: got grant %b out_valid %b want 10000/01111",
                            bus.grant, bus.out_valid);
      end
      checks++;
      if (bus.xbar_sel !== 25'h0084210) begin
         errors++; $display("FAIL bc_xbar_sel: got %h want 0084210", bus.xbar_sel);
      end
      checks++;
      if (dut.rr_ptr !== 3'd0 || dut.g_out[1].u_cc.count !== 3'd2
          || dut.g_out[0].u_cc.count !== 3'd3) begin
         errors++; $display("FAIL bc_state: got ptr %0d c1 %0d c0 %0d want 0/2/3",
                            dut.rr_ptr, dut.g_out[1].u_cc.count, dut.g_out[0].u_cc.count);
      end
      clear_inputs();
   endtask

   task automatic test_zero_mask();
      apply_reset();
      bus.req_valid      = 5'b01001;
      bus.req_port[4:0]   = 5'b10000;
      bus.req_port[19:15] = 5'b00000;
      step();
      checks++;
      if (bus.grant !== 5'b01001 || bus.out_valid !== 5'b10000) begin
         errors++; $display("FAIL zero_grant: got grant %b out_valid %b want 01001/10000",
                            bus.grant, bus.out_valid);
      end
      checks++;
      if (bus.xbar_sel !== 25'h0100000 || dut.rr_ptr !== 3'd1) begin
         errors++; $display("FAIL zero_sel_ptr: got sel %h ptr %0d want 0100000/1",
                            bus.xbar_sel, dut.rr_ptr);
      end
      clear_inputs();
   endtask

   task automatic test_reservation();
      logic [4:0] exp_g;
      apply_reset();
      // Drain output 0: grants land on alternate cycles until credit runs out.
      bus.req_valid     = 5'b00001;
      bus.req_port[4:0] = 5'b00001;
      for (int k = 1; k <= 8; k++) begin
         step();
         exp_g = ((k % 2) == 1 && k <= 7) ? 5'b00001 : 5'b00000;
         checks++;
         if (bus.grant !== exp_g) begin
            errors++; $display("FAIL drain_grant%0d: got %b want %b", k, bus.grant, exp_g);
         end
      end
      clear_inputs();
      checks++;
      if (dut.g_out[0].u_cc.count !== 3'd0) begin
         errors++; $display("FAIL drain_credit: got %0d want 0", dut.g_out[0].u_cc.count);
      end
      bus.req_valid      = 5'b01100;
      bus.req_port[14:10] = 5'b00011;
      bus.req_port[19:15] = 5'b00010;
      step();
      step();
      checks++;
      if (bus.grant !== 5'b0 || bus.out_valid !== 5'b0) begin
         errors++; $display("FAIL resv_block: got grant %b out_valid %b want 00000/00000",
                            bus.grant, bus.out_valid);
      end
      bus.credit_in = 5'b00001;
      step();
      bus.credit_in = 5'b00000;
      checks++;
      if (bus.grant !== 5'b0 || dut.g_out[0].u_cc.count !== 3'd1) begin
         errors++; $display("FAIL resv_credit_edge: got grant %b c0 %0d want 00000/1",
                            bus.grant, dut.g_out[0].u_cc.count);
      end
      step();
      checks++;
      if (bus.grant !== 5'b00100 || bus.out_valid !== 5'b00011 || dut.rr_ptr !== 3'd3) begin
         errors++; $display("FAIL resv_grant: got grant %b out_valid %b ptr %0d want 00100/00011/3",
                            bus.grant, bus.out_valid, dut.rr_ptr);
      end
      step();
      bus.req_valid[2] = 1'b0;
      checks++;
      if (bus.grant !== 5'b01000 || bus.out_valid !== 5'b00010) begin
         errors++; $display("FAIL resv_follow: got grant %b out_valid %b want 01000/00010",
                            bus.grant, bus.out_valid);
      end
      clear_inputs();
   endtask

   task automatic test_claim_and_credit();
      apply_reset();
      bus.req_valid     = 5'b00001;
      bus.req_port[4:0] = 5'b00010;
      bus.credit_in     = 5'b00010;
      step();
      bus.credit_in = 5'b00000;
      checks++;
      if (bus.grant !== 5'b00001 || dut.g_out[1].u_cc.count !== 3'd4) begin
         errors++; $display("FAIL cc_same_cycle: got grant %b c1 %0d want 00001/4",
                            bus.grant, dut.g_out[1].u_cc.count);
      end
      step();
      step();
      checks++;
      if (bus.grant !== 5'b00001 || dut.g_out[1].u_cc.count !== 3'd3) begin
         errors++; $display("FAIL cc_claim_only: got grant %b c1 %0d want 00001/3",
                            bus.grant, dut.g_out[1].u_cc.count);
      end
      bus.req_valid = 5'b0;
      bus.credit_in = 5'b00010;
      step();
      bus.credit_in = 5'b00000;
      checks++;
      if (dut.g_out[1].u_cc.count !== 3'd4) begin
         errors++; $display("FAIL cc_return: got %0d want 4", dut.g_out[1].u_cc.count);
      end
      bus.credit_in = 5'b00100;
      step();
      bus.credit_in = 5'b00000;
      checks++;
      if (dut.g_out[2].u_cc.count !== 3'd4) begin
         errors++; $display("FAIL cc_overflow: got %0d want 4", dut.g_out[2].u_cc.count);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.req_valid      = 5'b00011;
      bus.req_port[4:0]   = 5'b00100;
      bus.req_port[9:5]   = 5'b01000;
      step();
      checks++;
      if (bus.grant !== 5'b00011 || dut.rr_ptr !== 3'd1) begin
         errors++; $display("FAIL mid_pre: got grant %b ptr %0d want 00011/1",
                            bus.grant, dut.rr_ptr);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (bus.grant !== 5'b0 || bus.xbar_sel !== 25'b0 || bus.out_valid !== 5'b0) begin
         errors++; $display("FAIL mid_outputs: got grant %b sel %h out_valid %b want zeros",
                            bus.grant, bus.xbar_sel, bus.out_valid);
      end
      checks++;
      if (dut.rr_ptr !== 3'd0 || dut.g_out[2].u_cc.count !== 3'd4
          || dut.g_out[3].u_cc.count !== 3'd4) begin
         errors++; $display("FAIL mid_state: got ptr %0d c2 %0d c3 %0d want 0/4/4",
                            dut.rr_ptr, dut.g_out[2].u_cc.count, dut.g_out[3].u_cc.count);
      end
      clear_inputs();
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      clear_inputs();
      test_reset();
      test_unicast();
      test_broadcast();
      test_zero_mask();
      test_reservation();
      test_claim_and_credit();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
